instr_fetch_sequencer: RTL and testbench

//   Program sequencer for the 16-bit processor. Owns the PC, fetches instructions from program RAM,
//   and holds each one stable on the control circuit's INSTRUCTION input. Retires the instruction

---
 rtl/instr_fetch_sequencer_if.sv | 30 +++
 rtl/instr_fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// Program RAM and control-circuit bundle for the fetch sequencer.
// master = sequencer side, slave = RAM/control side.
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16
);
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_rden;
  logic [INSTR_W-1:0] ram_q;
  logic [INSTR_W-1:0] instr;
  logic               ctl_reset;
  logic               done;
  logic               pc_in;
  logic               pc_out;
  logic [DATA_W-1:0]  bus_in;
  logic [DATA_W-1:0]  bus_out;

  modport master (
    output ram_addr, ram_rden, instr,
    output ctl_reset, bus_out,
    input  ram_q, done, pc_in, pc_out, bus_in
  );

  modport slave (
    input  ram_addr, ram_rden, instr,
    input  ctl_reset, bus_out,
    output ram_q, done, pc_in, pc_out, bus_in
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer: owns the PC, fetches from program RAM and holds
// each instruction for the control circuit until its Done handshake.
module instr_fetch_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 16,
  parameter int DATA_W       = 16,
  parameter int RAM_LAT      = 1,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  instr_fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 retire,
  output logic                 halted,
  output logic                 error
);
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_UPDATE
  } state_t;

  state_t             r_state;
  logic [1:0]         r_wait;
  logic [TW-1:0]      r_tmo;
  logic               r_seen;
  logic               r_done_q;
  logic               r_branch;
  logic [ADDR_W-1:0]  r_tgt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic               r_rden;
  logic               r_ctl_reset;
  logic               r_retire;
  logic               r_halted;
  logic               r_error;
  logic [INSTR_W-1:0] r_instr;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [TW-1:0]      w_tmo_next;
  logic               w_fall;
  logic               w_unused;

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_pc_next  = r_branch ? r_tgt : w_pc_inc;
  assign w_tmo_next = r_tmo + 1'b1;
  assign w_fall     = r_done_q && !bus.done;
  assign w_unused   = &{1'b0, bus.bus_in[DATA_W-1:ADDR_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_tmo       <= '0;
      r_seen      <= 1'b0;
      r_done_q    <= 1'b0;
      r_branch    <= 1'b0;
      r_tgt       <= '0;
      r_pc        <= '0;
      r_ram_addr  <= '0;
      r_rden      <= 1'b0;
      r_ctl_reset <= 1'b1;
      r_retire    <= 1'b0;
      r_halted    <= 1'b1;
      r_error     <= 1'b0;
      r_instr     <= '0;
    end else begin
      r_retire <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (run && !r_error) begin
            r_state    <= S_FETCH;
            r_ram_addr <= r_pc;
            r_rden     <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
          r_rden  <= 1'b0;
          r_wait  <= '0;
        end
        S_WAIT: begin
          if (r_wait == 2'(RAM_LAT - 1)) begin
            r_instr     <= bus.ram_q;
            r_state     <= S_EXEC;
            r_ctl_reset <= 1'b0;
            r_tmo       <= '0;
            r_seen      <= 1'b0;
            r_done_q    <= 1'b0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_EXEC: begin
          r_done_q <= bus.done;
          if (bus.done) r_seen <= 1'b1;
          if (bus.pc_in) begin
            r_tgt    <= bus.bus_in[ADDR_W-1:0];
            r_branch <= 1'b1;
          end
          if (w_fall) begin
            r_state     <= S_UPDATE;
            r_retire    <= 1'b1;
            r_ctl_reset <= 1'b1;
          end else if (!r_seen && !bus.done) begin
            // only cycles before done has ever been high count
            if (w_tmo_next == TW'(EXEC_TIMEOUT)) begin
              r_error     <= 1'b1;
              r_state     <= S_IDLE;
              r_ctl_reset <= 1'b1;
              r_halted    <= 1'b1;
              r_branch    <= 1'b0;
              r_done_q    <= 1'b0;
            end else begin
              r_tmo <= w_tmo_next;
            end
          end
        end
        S_UPDATE: begin
          r_pc     <= w_pc_next;
          r_branch <= 1'b0;
          r_done_q <= 1'b0;
          if (run) begin
            r_state    <= S_FETCH;
            r_ram_addr <= w_pc_next;
            r_rden     <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_halted <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_rden  = r_rden;
  assign bus.instr     = r_instr;
  assign bus.ctl_reset = r_ctl_reset;
  assign bus.bus_out   = (r_state == S_EXEC && bus.pc_out)
                       ? DATA_W'(w_pc_inc) : '0;

  assign pc     = r_pc;
  assign retire = r_retire;
  assign halted = r_halted;
  assign error  = r_error;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against a PC/latency reference model.
module tb_instr_fetch_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] pc;
  logic       retire;
  logic       halted;
  logic       error;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];

  instr_fetch_sequencer_if ifc ();

  instr_fetch_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (ifc),
    .pc     (pc),
    .retire (retire),
    .halted (halted),
    .error  (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ifc.ram_rden) ifc.ram_q <= mem[ifc.ram_addr];

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    ifc.done = 1'b0;
    ifc.pc_in = 1'b0;
    ifc.pc_out = 1'b0;
    ifc.bus_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  task automatic wait_fetch(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.ram_rden === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.ctl_reset === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Drives one EXEC: pre low cycles, nhi high cycles, then a low cycle.
  // With br, pc_in is high twice; the second bus value is the target.
  task automatic exec_instr(
    input  int          pre,
    input  int          nhi,
    input  bit          br,
    input  logic [15:0] bv,
    input  bit          ldpc,
    output bit          ok,
    output logic [15:0] ins,
    output logic [15:0] b1,
    output logic [15:0] b0,
    output bit          st
  );
    wait_exec(ok);
    ins = ifc.instr;
    st = 1'b1;
    b1 = 'x;
    b0 = 'x;
    if (!ok) return;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (retire === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (ifc.instr !== ins) st = 1'b0;
      ifc.done = (c >= pre && c < pre + nhi);
      ifc.pc_in = br && (c < 2);
      ifc.bus_in = (c == 0) ? ~bv : bv;
      ifc.pc_out = ldpc && (c == 0);
      #1;
      if (c == 0) b1 = ifc.bus_out;
      if (c == 1) b0 = ifc.bus_out;
      @(negedge clk);
    end
    ifc.done = 1'b0;
    ifc.pc_in = 1'b0;
    ifc.pc_out = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ifc.pc_out = 1'b1;
    #1;
    n_checks++;
    if (halted !== 1'b1) begin
      n_errors++; $display("FAIL rst_halted: got %b want 1", halted);
    end
    n_checks++;
    if (pc !== 8'h00) begin
      n_errors++; $display("FAIL rst_pc: got %h want 00", pc);
    end
    n_checks++;
    if (ifc.instr !== 16'h0000) begin
      n_errors++; $display("FAIL rst_instr: got %h want 0000", ifc.instr);
    end
    n_checks++;
    if ({ifc.ram_rden, ifc.ctl_reset, retire, error} !== 4'b0100) begin
      n_errors++;
      $display("FAIL rst_ctl: got rden/ctl/ret/err %b want 0100",
               {ifc.ram_rden, ifc.ctl_reset, retire, error});
    end
    n_checks++;
    if (ifc.bus_out !== 16'h0000) begin
      n_errors++; $display("FAIL rst_busout: got %h want 0000", ifc.bus_out);
    end
    ifc.pc_out = 1'b0;
  endtask

  task automatic test_basic();
    bit ok, st;
    int t0, t1;
    logic [15:0] ins, b1, b0;
    fill_mem();
    mem[0] = 16'h4123;
    do_reset();
    run = 1'b1;
    wait_fetch(ok, t0);
    n_checks++;
    if (!ok || ifc.ram_addr !== 8'h00) begin
      n_errors++; $display("FAIL basic_fetch0: got ok=%b addr=%h want 1/00", ok, ifc.ram_addr);
    end
    exec_instr(1, 3, 1'b0, 16'h0, 1'b0, ok, ins, b1, b0, st);
    n_checks++;
    if (ins !== 16'h4123) begin
      n_errors++; $display("FAIL basic_instr: got %h want 4123", ins);
    end
    n_checks++;
    if (!ok || !st) begin
      n_errors++; $display("FAIL basic_retire: got ok=%b stable=%b want 1/1", ok, st);
    end
    @(negedge clk);
    n_checks++;
    if (retire !== 1'b0 || pc !== 8'h01) begin
      n_errors++; $display("FAIL basic_pc: got retire=%b pc=%h want 0/01", retire, pc);
    end
    wait_fetch(ok, t1);
    n_checks++;
    if (!ok || ifc.ram_addr !== 8'h01 || t1 - t0 !== 8) begin
      n_errors++;
      $display("FAIL basic_next: got addr=%h lat=%0d want 01/8", ifc.ram_addr, t1 - t0);
    end
  endtask

  task automatic test_branch();
    bit ok, st;
    int t;
    logic [15:0] ins, b1, b0;
    fill_mem();
    do_reset();
    run = 1'b1;
    exec_instr(0, 2, 1'b1, 16'h0042, 1'b0, ok, ins, b1, b0, st);
    wait_fetch(ok, t);
    n_checks++;
    if (!ok || pc !== 8'h42 || ifc.ram_addr !== 8'h42) begin
      n_errors++; $display("FAIL branch_42: got pc=%h addr=%h want 42/42", pc, ifc.ram_addr);
    end
    exec_instr(2, 1, 1'b1, 16'hA537, 1'b0, ok, ins, b1, b0, st);
    n_checks++;
    if (ins !== mem[8'h42]) begin
      n_errors++; $display("FAIL branch_instr: got %h want %h", ins, mem[8'h42]);
    end
    wait_fetch(ok, t);
    n_checks++;
    if (!ok || ifc.ram_addr !== 8'h37) begin
      n_errors++; $display("FAIL branch_last: got addr=%h want 37", ifc.ram_addr);
    end
  endtask

  task automatic test_ldpc();
    bit ok, st;
    int t;
    logic [15:0] ins, b1, b0;
    fill_mem();
    do_reset();
    run = 1'b1;
    exec_instr(0, 1, 1'b1, 16'h0010, 1'b0, ok, ins, b1, b0, st);
    wait_fetch(ok, t);
    exec_instr(1, 1, 1'b0, 16'h0, 1'b1, ok, ins, b1, b0, st);
    n_checks++;
    if (b1 !== 16'h0011) begin
      n_errors++; $display("FAIL ldpc_on: got %h want 0011", b1);
    end
    n_checks++;
    if (b0 !== 16'h0000) begin
      n_errors++; $display("FAIL ldpc_off: got %h want 0000", b0);
    end
  endtask

  task automatic test_wrap();
    bit ok, st;
    int t;
    logic [15:0] ins, b1, b0;
    fill_mem();
    do_reset();
    run = 1'b1;
    exec_instr(0, 1, 1'b1, 16'h00FF, 1'b0, ok, ins, b1, b0, st);
    wait_fetch(ok, t);
    n_checks++;
    if (ifc.ram_addr !== 8'hFF) begin
      n_errors++; $display("FAIL wrap_ff: got %h want ff", ifc.ram_addr);
    end
    exec_instr(0, 1, 1'b0, 16'h0, 1'b1, ok, ins, b1, b0, st);
    n_checks++;
    if (b1 !== 16'h0000 || ins !== mem[8'hFF]) begin
      n_errors++; $display("FAIL wrap_ldpc: got bus=%h ins=%h want 0000/%h", b1, ins, mem[8'hFF]);
    end
    wait_fetch(ok, t);
    n_checks++;
    if (!ok || pc !== 8'h00 || ifc.ram_addr !== 8'h00) begin
      n_errors++; $display("FAIL wrap_00: got pc=%h addr=%h want 00/00", pc, ifc.ram_addr);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    run = 1'b1;
    wait_exec(ok);
    repeat (14) @(negedge clk);
    n_checks++;
    if (!ok || error !== 1'b0 || ifc.ctl_reset !== 1'b0) begin
      n_errors++; $display("FAIL tmo_early: got ok=%b err=%b ctl=%b want 1/0/0", ok, error, ifc.ctl_reset);
    end
    @(negedge clk);
    n_checks++;
    if ({error, halted, ifc.ctl_reset} !== 3'b111) begin
      n_errors++; $display("FAIL tmo_hit: got err/halt/ctl=%b want 111", {error, halted, ifc.ctl_reset});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || error !== 1'b1 || ifc.ram_rden !== 1'b0) begin
      n_errors++; $display("FAIL tmo_stuck: got halt=%b err=%b rden=%b want 1/1/0", halted, error, ifc.ram_rden);
    end
    do_reset();
    n_checks++;
    if (error !== 1'b0) begin
      n_errors++; $display("FAIL tmo_clear: got %b want 0", error);
    end
  endtask

  task automatic test_run_drop();
    bit ok, st;
    logic [15:0] ins, b1, b0;
    fill_mem();
    do_reset();
    run = 1'b1;
    wait_exec(ok);
    run = 1'b0;
    exec_instr(1, 2, 1'b0, 16'h0, 1'b0, ok, ins, b1, b0, st);
    n_checks++;
    if (!ok) begin
      n_errors++; $display("FAIL drop_retire: got ok=%b want 1", ok);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || ifc.ram_rden !== 1'b0 || pc !== 8'h01) begin
      n_errors++; $display("FAIL drop_idle: got halt=%b rden=%b pc=%h want 1/0/01", halted, ifc.ram_rden, pc);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok, st;
    int t;
    logic [15:0] ins, b1, b0;
    fill_mem();
    mem[8'h33] = 16'hBEEF;
    do_reset();
    run = 1'b1;
    exec_instr(0, 1, 1'b1, 16'h0033, 1'b0, ok, ins, b1, b0, st);
    wait_fetch(ok, t);
    exec_instr(0, 1, 1'b1, 16'h0033, 1'b0, ok, ins, b1, b0, st);
    wait_fetch(ok, t);
    @(negedge clk);
    n_checks++;
    if (ifc.instr !== 16'hBEEF || pc !== 8'h33) begin
      n_errors++; $display("FAIL rw_pre: got instr=%h pc=%h want beef/33", ifc.instr, pc);
    end
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || pc !== 8'h00 || ifc.instr !== 16'h0000) begin
      n_errors++; $display("FAIL rw_idle: got halt=%b pc=%h instr=%h want 1/00/0000", halted, pc, ifc.instr);
    end
  endtask

  task automatic test_random();
    bit ok, st, br, ld;
    int t, t_prev, prev_len, pre, nhi;
    logic [7:0] pc_m;
    logic [15:0] ins, b1, b0, bv;
    fill_mem();
    do_reset();
    run = 1'b1;
    pc_m = 8'h00;
    t_prev = 0;
    prev_len = 0;
    for (int i = 0; i < 30; i++) begin
      pre = int'($urandom_range(0, 3));
      nhi = int'($urandom_range(1, 4));
      br = ($urandom_range(0, 3) == 0);
      ld = $urandom_range(0, 1) == 1;
      bv = 16'($urandom);
      wait_fetch(ok, t);
      n_checks++;
      if (!ok || ifc.ram_addr !== pc_m || pc !== pc_m) begin
        n_errors++; $display("FAIL rnd_fetch[%0d]: got addr=%h pc=%h want %h", i, ifc.ram_addr, pc, pc_m);
      end
      if (i > 0) begin
        n_checks++;
        if (t - t_prev !== prev_len) begin
          n_errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, t - t_prev, prev_len);
        end
      end
      exec_instr(pre, nhi, br, bv, ld, ok, ins, b1, b0, st);
      n_checks++;
      if (!ok || !st || ins !== mem[pc_m]) begin
        n_errors++; $display("FAIL rnd_exec[%0d]: got ok=%b st=%b ins=%h want 1/1/%h", i, ok, st, ins, mem[pc_m]);
      end
      n_checks++;
      if (b1 !== (ld ? {8'h00, pc_m + 8'h01} : 16'h0000) || b0 !== 16'h0000) begin
        n_errors++; $display("FAIL rnd_bus[%0d]: got %h/%h pc=%h ld=%b", i, b1, b0, pc_m, ld);
      end
      t_prev = t;
      prev_len = 1 + 1 + (pre + nhi + 1) + 1;
      pc_m = br ? bv[7:0] : pc_m + 8'h01;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_ldpc();
    test_wrap();
    test_timeout();
    test_run_drop();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
